// File: rtl/axis_to_axi_adapter.sv
// -----------------------------------------------------------------------------
// axis_to_axi_adapter
//
// Turns one stream transfer command (start byte address + total beat count)
// into a train of AXI4 INCR address bursts of at most 256 beats each, and
// passes the matching data stream straight through while generating LAST.
// Used in both directions: memory read data -> stream, stream -> AXI W.
//
// Optional feature (compile-time macro):
//   AXIS_TO_AXI_ADAPTER_4K_BOUNDARY_SPLIT_EN
//     defined   : bursts additionally end before a 4 KiB address boundary,
//                 and per-burst LAST follows those split burst ends.
//     undefined : bursts are limited only by the 256-beat cap.
//
// Ports
//   aclk, resetn            clock, asynchronous active-low reset
//   s_avalid/s_aready       command handshake; s_aready doubles as "idle"
//   s_aaddr, s_abeats       start byte address, total beat count
//   enableAxiLastSignal     1: LAST per AXI burst end, 0: LAST on final beat
//   s_x*                    input stream (s_xlast is ignored)
//   m_x*                    output stream, LAST generated here
//   m_ax*                   AXI address channel (INCR bursts, ID 0)
// -----------------------------------------------------------------------------
module axis_to_axi_adapter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = 4,
   parameter int ID_WIDTH   = 8
) (
   input  logic                  aclk,
   input  logic                  resetn,
   // command
   input  logic                  s_avalid,
   input  logic [ADDR_WIDTH-1:0] s_aaddr,
   input  logic [ADDR_WIDTH-1:0] s_abeats,
   output logic                  s_aready,
   input  logic                  enableAxiLastSignal,
   // input stream
   input  logic [DATA_WIDTH-1:0] s_xdata,
   input  logic [STRB_WIDTH-1:0] s_xstrb,
   input  logic                  s_xlast,
   input  logic                  s_xvalid,
   output logic                  s_xready,
   // output stream
   output logic [DATA_WIDTH-1:0] m_xdata,
   output logic [STRB_WIDTH-1:0] m_xstrb,
   output logic                  m_xlast,
   output logic                  m_xvalid,
   input  logic                  m_xready,
   // AXI address channel
   output logic [ID_WIDTH-1:0]   m_axid,
   output logic [ADDR_WIDTH-1:0] m_axaddr,
   output logic [7:0]            m_axlen,
   output logic [2:0]            m_axsize,
   output logic [1:0]            m_axburst,
   output logic                  m_axlock,
   output logic [3:0]            m_axcache,
   output logic [2:0]            m_axprot,
   output logic                  m_axvalid,
   input  logic                  m_axready
);

   localparam int                    SIZE      = $clog2(STRB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] MAX_BURST = ADDR_WIDTH'(256);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   // Beats in the next burst: remaining beats, capped at 256 and at the room
   // left before the next split point.
   function automatic logic [8:0] f_burst_beats(input logic [ADDR_WIDTH-1:0] i_rem,
                                                input logic [12:0]           i_room);
      logic [8:0] v_beats;
      v_beats = (i_rem > MAX_BURST) ? 9'd256 : i_rem[8:0];
      if ({4'd0, v_beats} > i_room) v_beats = i_room[8:0];
      return v_beats;
   endfunction

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;   // next burst address
   logic [ADDR_WIDTH-1:0] r_arem, w_arem_nxt;   // beats not yet covered by a burst
   logic [ADDR_WIDTH-1:0] r_drem, w_drem_nxt;   // data beats not yet transferred
   logic [7:0]            r_axlen;
   logic                  r_axvalid;
   logic                  r_last_en;
   logic [8:0]            r_dleft;              // beats left in current data burst, 0 = new burst
   logic                  w_accept, w_afire, w_dfire, w_data_active;
   logic [8:0]            w_alen_p1, w_nlen_p1, w_dburst;
   logic [12:0]           w_room_a, w_room_d;
   logic                  w_unused;

   assign w_unused = s_xlast;

`ifdef AXIS_TO_AXI_ADAPTER_4K_BOUNDARY_SPLIT_EN
   // Beats that fit before the next 4 KiB boundary. Rounded up so an
   // unaligned start still yields a non-empty burst.
   function automatic logic [12:0] f_page_room(input logic [11:0] i_off);
      return (13'd4096 - {1'b0, i_off} + 13'(STRB_WIDTH - 1)) >> SIZE;
   endfunction

   // The data side tracks its own page offset so per-burst LAST stays
   // correct even when data runs ahead of the address handshakes.
   logic [11:0] r_doff;

   assign w_room_a = f_page_room(w_addr_nxt[11:0]);
   assign w_room_d = f_page_room(r_doff);

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn)        r_doff <= '0;
      else if (w_accept)  r_doff <= s_aaddr[11:0];
      else if (w_dfire)   r_doff <= r_doff + 12'(STRB_WIDTH);
   end
`else
   assign w_room_a = 13'd256;
   assign w_room_d = 13'd256;
`endif

   // ---------------- data path (combinational pass-through) ----------------
   assign w_data_active = (r_state == S_BUSY) && (r_drem != '0);
   assign w_dfire       = s_xvalid && m_xready && w_data_active;
   assign w_dburst      = (r_dleft == 9'd0) ? f_burst_beats(r_drem, w_room_d) : r_dleft;

   assign m_xdata  = s_xdata;
   assign m_xstrb  = s_xstrb;
   assign m_xvalid = s_xvalid && w_data_active;
   assign s_xready = m_xready && w_data_active;
   assign m_xlast  = r_last_en ? (w_dburst == 9'd1) : (r_drem == ADDR_WIDTH'(1));

   // ---------------- address side ----------------
   assign w_afire   = r_axvalid && m_axready;
   assign w_alen_p1 = {1'b0, r_axlen} + 9'd1;
   assign w_nlen_p1 = f_burst_beats(w_arem_nxt, w_room_a);

   // NOTE: every signal driven here gets a default first so no path leaves
   // it unassigned; that is what keeps this block free of inferred latches.
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_arem_nxt  = r_arem;
      w_drem_nxt  = r_drem;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (s_avalid) begin
               w_accept   = 1'b1;
               w_addr_nxt = s_aaddr;
               w_arem_nxt = s_abeats;
               w_drem_nxt = s_abeats;
               // A zero-beat command completes on acceptance.
               if (s_abeats != '0) w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (w_afire) begin
               w_addr_nxt = r_addr + (ADDR_WIDTH'(w_alen_p1) << SIZE);
               w_arem_nxt = r_arem - ADDR_WIDTH'(w_alen_p1);
            end
            if (w_dfire) w_drem_nxt = r_drem - ADDR_WIDTH'(1);
            // Looking at the next-cycle counts lets s_aready rise the cycle
            // right after the last handshake of either side.
            if ((w_arem_nxt == '0) && (w_drem_nxt == '0)) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_arem    <= '0;
         r_drem    <= '0;
         r_axvalid <= 1'b0;
         r_axlen   <= '0;
         r_last_en <= 1'b0;
         r_dleft   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_addr    <= w_addr_nxt;
         r_arem    <= w_arem_nxt;
         r_drem    <= w_drem_nxt;
         // Address/len are recomputed from unchanged inputs while waiting,
         // so they stay stable until the handshake.
         r_axvalid <= (w_state_nxt == S_BUSY) && (w_arem_nxt != '0);
         r_axlen   <= (w_arem_nxt != '0) ? 8'(w_nlen_p1 - 9'd1) : 8'd0;
         if (w_accept) begin
            r_last_en <= enableAxiLastSignal;
            r_dleft   <= '0;
         end else if (w_dfire) begin
            r_dleft   <= w_dburst - 9'd1;
         end
      end
   end

   assign s_aready  = (r_state == S_IDLE);
   assign m_axvalid = r_axvalid;
   assign m_axaddr  = r_addr;
   assign m_axlen   = r_axlen;
   assign m_axsize  = 3'(SIZE);
   assign m_axburst = 2'b01;
   assign m_axid    = '0;
   assign m_axlock  = 1'b0;
   assign m_axcache = 4'h0;
   assign m_axprot  = 3'h0;

endmodule

// File: tb/tb_axis_to_axi_adapter.sv
// -----------------------------------------------------------------------------
// Testbench for axis_to_axi_adapter.
// Stimulus pushes expected bursts and beats into queues computed by a simple
// burst-splitting model; independent monitors pop and compare whenever the
// DUT presents an address handshake or an output stream beat.
// -----------------------------------------------------------------------------
module tb_axis_to_axi_adapter;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = 4;
   localparam int IW = 8;

   logic          aclk, resetn;
   logic          s_avalid, s_aready, enableAxiLastSignal;
   logic [AW-1:0] s_aaddr, s_abeats;
   logic [DW-1:0] s_xdata, m_xdata;
   logic [SW-1:0] s_xstrb, m_xstrb;
   logic          s_xlast, s_xvalid, s_xready;
   logic          m_xlast, m_xvalid, m_xready;
   logic [IW-1:0] m_axid;
   logic [AW-1:0] m_axaddr;
   logic [7:0]    m_axlen;
   logic [2:0]    m_axsize, m_axprot;
   logic [1:0]    m_axburst;
   logic          m_axlock;
   logic [3:0]    m_axcache;
   logic          m_axvalid, m_axready;

   axis_to_axi_adapter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)
   ) dut (
      .aclk(aclk), .resetn(resetn),
      .s_avalid(s_avalid), .s_aaddr(s_aaddr), .s_abeats(s_abeats), .s_aready(s_aready),
      .enableAxiLastSignal(enableAxiLastSignal),
      .s_xdata(s_xdata), .s_xstrb(s_xstrb), .s_xlast(s_xlast), .s_xvalid(s_xvalid),
      .s_xready(s_xready),
      .m_xdata(m_xdata), .m_xstrb(m_xstrb), .m_xlast(m_xlast), .m_xvalid(m_xvalid),
      .m_xready(m_xready),
      .m_axid(m_axid), .m_axaddr(m_axaddr), .m_axlen(m_axlen), .m_axsize(m_axsize),
      .m_axburst(m_axburst), .m_axlock(m_axlock), .m_axcache(m_axcache),
      .m_axprot(m_axprot), .m_axvalid(m_axvalid), .m_axready(m_axready)
   );

   typedef struct packed {logic [31:0] addr; logic [7:0] len;} aw_t;
   typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} beat_t;

   aw_t   aw_q[$], obs_aw[$];
   beat_t d_q[$];
   bit    last_q[$];
   int    obs_last[$];
   int    checks = 0, failures = 0, cyc = 0;
   int    last_aw_cyc = 0, last_d_cyc = 0, beat_idx = 0;
   bit    bp = 0, pend = 0;
   aw_t   pend_aw;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial forever begin
      @(posedge aclk);
      cyc++;
   end

   // Random backpressure on the two DUT-facing ready inputs.
   initial forever begin
      @(posedge aclk);
      #1;
      m_xready  = bp ? 1'($urandom) : 1'b1;
      m_axready = bp ? 1'($urandom) : 1'b1;
   end

   // Reference model: split the transfer into INCR bursts and mark LAST beats.
   task automatic model_cmd(input logic [31:0] addr, input int beats, input bit en);
      logic [31:0] a;
      int rem, k, n;
      a = addr; rem = beats; k = 0;
      while (rem > 0) begin
         n = (rem < 256) ? rem : 256;
`ifdef AXIS_TO_AXI_ADAPTER_4K_BOUNDARY_SPLIT_EN
         begin
            int room;
            room = (4096 - int'({20'd0, a[11:0]})) / SW;
            if (n > room) n = room;
         end
`endif
         aw_q.push_back('{addr: a, len: 8'(n - 1)});
         for (int j = 1; j <= n; j++) begin
            k++;
            last_q.push_back(en ? (j == n) : (k == beats));
         end
         a   = a + 32'(n * SW);
         rem = rem - n;
      end
   endtask

   // Monitors: sampled on the falling edge, away from the active edge.
   always @(negedge aclk) begin
      aw_t   e;
      beat_t b;
      if (!resetn) begin
         pend = 1'b0;
      end else begin
         if (m_axvalid) begin
            if (pend) begin
               check("aw_addr_stable", m_axaddr, pend_aw.addr);
               check("aw_len_stable", m_axlen, pend_aw.len);
            end
            if (m_axready) begin
               if (aw_q.size() == 0) fail("aw_unexpected");
               else begin
                  e = aw_q.pop_front();
                  check("aw_addr", m_axaddr, e.addr);
                  check("aw_len", m_axlen, e.len);
                  check("aw_consts", {m_axid, m_axsize, m_axburst, m_axlock, m_axcache, m_axprot},
                        {8'h00, 3'd2, 2'd1, 1'b0, 4'h0, 3'h0});
               end
               obs_aw.push_back('{addr: m_axaddr, len: m_axlen});
               last_aw_cyc = cyc;
               pend = 1'b0;
            end else begin
               pend    = 1'b1;
               pend_aw = '{addr: m_axaddr, len: m_axlen};
            end
         end else if (pend) begin
            fail("aw_valid_dropped");
            pend = 1'b0;
         end
         if (m_xvalid && m_xready) begin
            beat_idx++;
            if (m_xlast) obs_last.push_back(beat_idx);
            last_d_cyc = cyc;
            if (d_q.size() == 0) fail("beat_unexpected");
            else begin
               b = d_q.pop_front();
               check("beat_data", m_xdata, b.data);
               check("beat_strb", m_xstrb, b.strb);
               check("beat_last", m_xlast, b.last);
            end
         end
      end
   end

   task automatic drive_data(input int n);
      beat_t b;
      int    t;
      bit    hs;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            s_xvalid = 1'b0;
            s_xlast  = 1'($urandom);
            @(posedge aclk);
            #1;
         end
         if (last_q.size() == 0) begin
            fail("model_underrun");
            s_xvalid = 1'b0;
            return;
         end
         b.data = $urandom;
         b.strb = 4'($urandom);
         b.last = last_q.pop_front();
         d_q.push_back(b);
         s_xdata  = b.data;
         s_xstrb  = b.strb;
         s_xlast  = 1'($urandom);
         s_xvalid = 1'b1;
         t = 0;
         do begin
            @(negedge aclk);
            hs = s_xready;
            @(posedge aclk);
            #1;
            t++;
         end while (!hs && t < 2000);
         if (!hs) begin
            fail("beat_timeout");
            s_xvalid = 1'b0;
            return;
         end
      end
      s_xvalid = 1'b0;
   endtask

   task automatic issue_cmd(input logic [31:0] addr, input int beats, input bit en);
      model_cmd(addr, beats, en);
      obs_aw.delete();
      obs_last.delete();
      beat_idx = 0; last_aw_cyc = 0; last_d_cyc = 0;
      s_aaddr = addr; s_abeats = 32'(beats); enableAxiLastSignal = en; s_avalid = 1'b1;
      @(negedge aclk);
      check("cmd_ready", s_aready, 1);
      @(posedge aclk);
      #1;
      // Scramble the command inputs to show they were latched.
      s_avalid = 1'b0; s_aaddr = $urandom; s_abeats = $urandom;
      enableAxiLastSignal = 1'($urandom);
   endtask

   task automatic run_cmd(input logic [31:0] addr, input int beats, input bit en);
      int t, done;
      issue_cmd(addr, beats, en);
      if (beats == 0) begin
         s_xvalid = 1'b1;
         repeat (3) begin
            @(negedge aclk);
            check("zero_cmd_idle", {s_aready, m_axvalid, m_xvalid, s_xready}, 4'b1000);
         end
         s_xvalid = 1'b0;
      end else begin
         check("busy_after_accept", s_aready, 0);
         drive_data(beats);
         t = 0;
         do begin
            @(negedge aclk);
            t++;
         end while (!s_aready && t < 20000);
         if (!s_aready) fail("done_timeout");
         else begin
            done = (last_aw_cyc > last_d_cyc) ? last_aw_cyc : last_d_cyc;
            check("done_cycle", cyc, done + 1);
         end
      end
      check("aw_q_drained", aw_q.size(), 0);
      check("d_q_drained", d_q.size(), 0);
      @(posedge aclk);
      #1;
   endtask

   task automatic check_bursts(input string tag, input int n, input logic [31:0] a0,
                               input logic [7:0] l0, input logic [31:0] a1, input logic [7:0] l1);
      check({tag, "_nbursts"}, obs_aw.size(), n);
      if (obs_aw.size() > 0) check({tag, "_burst0"}, obs_aw[0], {a0, l0});
      if (n > 1 && obs_aw.size() > 1) check({tag, "_burst1"}, obs_aw[1], {a1, l1});
   endtask

   task automatic check_lasts(input string tag, input int n, input int i0, input int i1);
      check({tag, "_nlast"}, obs_last.size(), n);
      if (obs_last.size() > 0) check({tag, "_last0"}, obs_last[0], i0);
      if (n > 1 && obs_last.size() > 1) check({tag, "_last1"}, obs_last[1], i1);
   endtask

   initial begin
      logic [31:0] ra;
      resetn = 1'b0;
      s_avalid = 1'b0; s_aaddr = '0; s_abeats = '0; enableAxiLastSignal = 1'b0;
      s_xdata = '0; s_xstrb = '0; s_xlast = 1'b0; s_xvalid = 1'b1;
      m_xready = 1'b1; m_axready = 1'b1;
      #12;
      check("reset_state", {s_aready, m_axvalid, m_xvalid, s_xready}, 4'b1000);
      s_xvalid = 1'b0;
      @(posedge aclk);
      #4 resetn = 1'b1;
      @(posedge aclk);
      #1;

      // Directed cases without backpressure.
      run_cmd(32'h1000, 4, 1'b1);
      check_bursts("t_single", 1, 32'h1000, 8'd3, 32'h0, 8'd0);
      check_lasts("t_single", 1, 4, 0);

      run_cmd(32'h1000, 300, 1'b1);
      check_bursts("t_300_en", 2, 32'h1000, 8'd255, 32'h1400, 8'd43);
      check_lasts("t_300_en", 2, 256, 300);

      run_cmd(32'h1000, 300, 1'b0);
      check_bursts("t_300_dis", 2, 32'h1000, 8'd255, 32'h1400, 8'd43);
      check_lasts("t_300_dis", 1, 300, 0);

      run_cmd(32'h0FF0, 8, 1'b1);
`ifdef AXIS_TO_AXI_ADAPTER_4K_BOUNDARY_SPLIT_EN
      check_bursts("t_4k", 2, 32'h0FF0, 8'd3, 32'h1000, 8'd3);
      check_lasts("t_4k", 2, 4, 8);
`else
      check_bursts("t_4k", 1, 32'h0FF0, 8'd7, 32'h0, 8'd0);
      check_lasts("t_4k", 1, 8, 0);
`endif

      run_cmd(32'h5000, 0, 1'b1);
      check("t_zero_nbursts", obs_aw.size(), 0);

      // Randomized commands under 50% backpressure on both readies.
      bp = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ra = $urandom & 32'hFFFF_FFFC;
         run_cmd(ra, $urandom_range(1, 600), 1'($urandom));
      end
      run_cmd(32'hFFFF_FF00, 100, 1'b1);

      // Reset in the middle of a 300-beat transfer, after beat 10.
      issue_cmd(32'h2000, 300, 1'b1);
      drive_data(10);
      s_xvalid = 1'b1;
      s_xdata  = $urandom;
      #2 resetn = 1'b0;
      #1;
      check("rst_mid_outputs", {m_axvalid, m_xvalid, s_aready, s_xready}, 4'b0010);
      aw_q.delete();
      d_q.delete();
      last_q.delete();
      s_xvalid = 1'b0;
      @(posedge aclk);
      #4 resetn = 1'b1;
      @(posedge aclk);
      #1;
      check("rst_ready_after", s_aready, 1);

      run_cmd(32'h3000, 2, 1'b1);
      check_bursts("t_after_rst", 1, 32'h3000, 8'd1, 32'h0, 8'd0);
      check_lasts("t_after_rst", 1, 2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/axis_to_axi_adapter.md
Name: axis_to_axi_adapter

Overview:
- Converts one stream transfer command (start address + total beat count) into a sequence of AXI4 INCR address bursts of at most 256 beats each.
- Passes a data stream straight through, gated by the active command, and generates the TLAST for each data beat.
- Sits between the AXIS-to-AXI crossbar arbitration and the memory AXI port.
- Serves both directions: memory read data flows to the stream; stream write data flows to AXI W.

Parameters:
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 32, address width; also the width of the beat-count input.
- STRB_WIDTH, 4, bytes per beat (DATA_WIDTH/8); must be a power of two.
- ID_WIDTH, 8, AXI ID width.

Ports:
- aclk  in  1  clock; all logic on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- s_avalid  in  1  command valid.
- s_aaddr  in  ADDR_WIDTH  start byte address.
- s_abeats  in  ADDR_WIDTH  total beats in the transfer.
- s_aready  out  1  command accepted / adapter idle.
- enableAxiLastSignal  in  1  1 = last marks each AXI burst end; 0 = last marks end of the whole transfer.
- s_xdata  in  DATA_WIDTH  input stream data.
- s_xstrb  in  STRB_WIDTH  input stream byte strobes.
- s_xlast  in  1  input stream last (ignored).
- s_xvalid  in  1  input stream valid.
- s_xready  out  1  input stream ready.
- m_xdata  out  DATA_WIDTH  output stream data.
- m_xstrb  out  STRB_WIDTH  output stream byte strobes.
- m_xlast  out  1  generated last.
- m_xvalid  out  1  output stream valid.
- m_xready  in  1  output stream ready.
- m_axid  out  ID_WIDTH  AXI ID; constant 0.
- m_axaddr  out  ADDR_WIDTH  AXI burst address.
- m_axlen  out  8  AXI burst length minus 1.
- m_axsize  out  3  clog2(STRB_WIDTH).
- m_axburst  out  2  constant 1 (INCR).
- m_axlock  out  1  constant 0.
- m_axcache  out  4  constant 0.
- m_axprot  out  3  constant 0.
- m_axvalid  out  1  AXI address valid.
- m_axready  in  1  AXI address ready.

Behaviour:
- Reset values: s_aready=1, m_axvalid=0, data path inactive, all counters 0.
- Reset is asynchronous and may be asserted mid-transfer; the current command is abandoned.
- States: IDLE, BUSY.
- IDLE:
  - s_aready=1.
  - On s_avalid: latch addr, beats and enableAxiLastSignal; go BUSY; s_aready=0 from the next cycle.
  - A command with beats=0 is accepted and completes immediately, issuing no bursts and no data.
- BUSY, address side:
  - Present m_axvalid with len = min(remaining_addr_beats, 256) - 1.
  - On each m_axvalid && m_axready: address += (len+1)*STRB_WIDTH (ADDR_WIDTH wrap-around); remaining_addr_beats -= len+1.
  - Deassert m_axvalid when remaining_addr_beats reaches 0.
  - m_axvalid/addr/len are registered and held stable until the handshake.
- BUSY, data side (combinational pass-through, no added latency):
  - m_xdata=s_xdata, m_xstrb=s_xstrb.
  - m_xvalid = s_xvalid && data_active; s_xready = m_xready && data_active.
  - A beat transfers when s_xvalid && m_xready && data_active.
  - Data runs independently of address progress; data beats may precede the matching address handshake.
- m_xlast:
  - enableAxiLastSignal=1: high on beat 256, 512, … and on the final beat (per-burst AXI WLAST).
  - enableAxiLastSignal=0: high only on the final beat of the whole transfer (stream TLAST); s_xlast is never forwarded.
- Return to IDLE once all address bursts and all data beats have completed. s_aready rises the cycle after the final one of the two completes.
- Simultaneous final address handshake and final data beat in one cycle → IDLE next cycle.

Optional Feature:
- Macro AXIS_TO_AXI_ADAPTER_4K_BOUNDARY_SPLIT_EN.
- Defined: a burst additionally ends before crossing a 4 KiB address boundary: len+1 = min(remaining, 256, (4096 - addr[11:0])/STRB_WIDTH). With enableAxiLastSignal=1, m_xlast follows these split burst ends.
- Undefined: bursts are limited only by the 256-beat cap.

Test Plan:
- addr=0x1000, beats=4, STRB_WIDTH=4, enable=1 → one burst: addr 0x1000, len 3, size 2, burst 1; m_xlast on beat 4; s_aready back to 1 after it.
- addr=0x1000, beats=300, enable=1 → bursts (0x1000, len 255) then (0x1400, len 43); m_xlast on beats 256 and 300.
- Same command with enable=0 → identical bursts; m_xlast only on beat 300; s_xlast toggled randomly has no effect.
- m_xready and m_axready random backpressure, 50% → no beat lost or duplicated; addr/len stable while m_axvalid is high and not accepted.
- resetn pulsed low mid-transfer (beat 10 of 300) → m_axvalid=0, m_xvalid=0, s_aready=1 immediately; the next command (beats=2) runs cleanly.
- Macro defined, addr=0x0FF0, beats=8 → bursts (0x0FF0, len 3) and (0x1000, len 3); undefined → a single burst (0x0FF0, len 7).
